// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bus between the pipeline datapath and pipeline_hazard_ctrl.
// master: datapath side (drives D-stage fields and E/M status, receives controls)
// slave : controller side (receives D-stage fields and status, drives stall/flush/forward
//         controls and the stall/flush performance counters)
interface pipeline_hazard_ctrl_if #(
  parameter int unsigned CNT_W = 32
);
  localparam int unsigned REG_W = 5;

  // D-stage instruction fields
  logic             id_valid;
  logic [REG_W-1:0] id_rs1;
  logic [REG_W-1:0] id_rs2;
  logic             id_use_rs1;
  logic             id_use_rs2;
  logic [REG_W-1:0] id_rd;
  logic             id_regwrite;
  logic             id_memread;
  logic             id_memwrite;
  // E / M status
  logic             ex_branch_taken;
  logic             ex_busy;
  logic             mem_ready;
  // pipeline register controls
  logic             stall_f;
  logic             stall_d;
  logic             flush_d;
  logic             flush_e;
  logic             freeze_e;
  logic             freeze_m;
  logic             bubble_m;
  logic             bubble_w;
  // E operand forwarding selects
  logic [1:0]       fwd_a;
  logic [1:0]       fwd_b;
  // performance counters
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd,
           id_regwrite, id_memread, id_memwrite,
           ex_branch_taken, ex_busy, mem_ready,
    input  stall_f, stall_d, flush_d, flush_e, freeze_e, freeze_m,
           bubble_m, bubble_w, fwd_a, fwd_b, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd,
           id_regwrite, id_memread, id_memwrite,
           ex_branch_taken, ex_busy, mem_ready,
    output stall_f, stall_d, flush_d, flush_e, freeze_e, freeze_m,
           bubble_m, bubble_w, fwd_a, fwd_b, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall / flush / forwarding controller for a 5-stage RV32I pipeline.
// Keeps shadow copies of the E, M and W instructions and, with zero latency,
// resolves memory-wait, multicycle-busy, taken-branch and load-use hazards
// (in that priority) into pipeline register controls and E-operand forwards.
// Ports:
//   clk   - rising-edge clock
//   reset - synchronous active-high reset
//   hz    - slave side of pipeline_hazard_ctrl_if (D fields, E/M status in;
//           stall/flush/freeze/bubble, fwd_a/fwd_b, stall_cnt/flush_cnt out)
module pipeline_hazard_ctrl #(
  parameter int unsigned CNT_W = 32
) (
  input logic                   clk,
  input logic                   reset,
  pipeline_hazard_ctrl_if.slave hz
);

  localparam int unsigned REG_W = 5;

  typedef struct packed {
    logic             v;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic [REG_W-1:0] rd;
    logic             rw;
    logic             mr;
    logic             mop;
  } e_slot_t;

  typedef struct packed {
    logic             v;
    logic [REG_W-1:0] rd;
    logic             rw;
    logic             mop;
  } m_slot_t;

  typedef struct packed {
    logic             v;
    logic [REG_W-1:0] rd;
    logic             rw;
  } w_slot_t;

  e_slot_t          e_q, e_d;
  m_slot_t          m_q, m_d;
  w_slot_t          w_q, w_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic       mstall, xstall, br, lu;
  logic       stall_f, stall_d, flush_d, flush_e;
  logic       freeze_e, freeze_m, bubble_m, bubble_w;
  logic [1:0] fwd_a, fwd_b;

  // Forward select for one E operand; the younger M result wins over W, x0 never forwards.
  function automatic logic [1:0] fwd_sel(input logic [REG_W-1:0] rs,
                                         input m_slot_t m, input w_slot_t w);
    logic [1:0] sel;
    sel = 2'b00;
    if (m.v && m.rw && (m.rd != '0) && (m.rd == rs)) begin
      sel = 2'b10;
    end else if (w.v && w.rw && (w.rd != '0) && (w.rd == rs)) begin
      sel = 2'b01;
    end
    return sel;
  endfunction

  // Raw hazard terms; xstall is masked by mstall so the two never overlap.
  always_comb begin
    mstall = m_q.v & m_q.mop & ~hz.mem_ready;
    xstall = e_q.v & hz.ex_busy & ~mstall;
    br     = e_q.v & hz.ex_branch_taken;
    lu     = hz.id_valid & e_q.v & e_q.mr & (e_q.rd != '0) &
             ((hz.id_use_rs1 & (hz.id_rs1 == e_q.rd)) |
              (hz.id_use_rs2 & (hz.id_rs2 == e_q.rd)));
  end

  // Prioritised control outputs and slot advance.
  always_comb begin
    stall_f  = 1'b0;
    stall_d  = 1'b0;
    flush_d  = 1'b0;
    flush_e  = 1'b0;
    freeze_e = 1'b0;
    freeze_m = 1'b0;
    bubble_m = 1'b0;
    bubble_w = 1'b0;
    e_d      = e_q;
    m_d      = m_q;
    w_d      = w_q;

    if (reset) begin
      flush_d  = 1'b1;
      flush_e  = 1'b1;
      bubble_m = 1'b1;
      bubble_w = 1'b1;
    end else if (mstall) begin
      stall_f  = 1'b1;
      stall_d  = 1'b1;
      freeze_e = 1'b1;
      freeze_m = 1'b1;
      bubble_w = 1'b1;
      w_d      = '0;
    end else if (xstall) begin
      stall_f  = 1'b1;
      stall_d  = 1'b1;
      freeze_e = 1'b1;
      bubble_m = 1'b1;
      m_d      = '0;
      w_d      = '{v: m_q.v, rd: m_q.rd, rw: m_q.rw};
    end else begin
      w_d = '{v: m_q.v, rd: m_q.rd, rw: m_q.rw};
      m_d = '{v: e_q.v, rd: e_q.rd, rw: e_q.rw, mop: e_q.mop};
      if (br) begin
        flush_d = 1'b1;
        flush_e = 1'b1;
        e_d     = '0;
      end else if (lu) begin
        // D is held and a bubble goes to E for one cycle
        stall_f = 1'b1;
        stall_d = 1'b1;
        flush_e = 1'b1;
        e_d     = '0;
      end else begin
        e_d = '{v:   hz.id_valid,
                rs1: hz.id_rs1,
                rs2: hz.id_rs2,
                rd:  hz.id_rd,
                rw:  hz.id_regwrite,
                mr:  hz.id_memread,
                mop: hz.id_memread | hz.id_memwrite};
      end
    end

    // Forwards stay live through freezes so the held E instruction keeps fresh operands.
    fwd_a = reset ? 2'b00 : fwd_sel(e_q.rs1, m_q, w_q);
    fwd_b = reset ? 2'b00 : fwd_sel(e_q.rs2, m_q, w_q);

    stall_cnt_d = stall_cnt_q + CNT_W'(stall_f);
    flush_cnt_d = flush_cnt_q + CNT_W'(flush_d);
  end

  // Slot and counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      e_q         <= '0;
      m_q         <= '0;
      w_q         <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      e_q         <= e_d;
      m_q         <= m_d;
      w_q         <= w_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign hz.stall_f   = stall_f;
  assign hz.stall_d   = stall_d;
  assign hz.flush_d   = flush_d;
  assign hz.flush_e   = flush_e;
  assign hz.freeze_e  = freeze_e;
  assign hz.freeze_m  = freeze_m;
  assign hz.bubble_m  = bubble_m;
  assign hz.bubble_w  = bubble_w;
  assign hz.fwd_a     = fwd_a;
  assign hz.fwd_b     = fwd_b;
  assign hz.stall_cnt = stall_cnt_q;
  assign hz.flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: a per-cycle reference model of the
// E/M/W occupancy plus directed scenarios with literal expectations.
module tb_pipeline_hazard_ctrl;

  logic clk;
  logic reset;

  pipeline_hazard_ctrl_if #(.CNT_W(32)) hz ();

  pipeline_hazard_ctrl #(.CNT_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic       v;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       rw;
    logic       mr;
    logic       mop;
  } ins_t;

  localparam int K_NONE = 0, K_RST = 1, K_MST = 2, K_XST = 3, K_BR = 4, K_LU = 5;

  // pipe[0]=E, pipe[1]=M, pipe[2]=W
  ins_t        pipe [3] = '{default: '0};
  ins_t        nxt  [3];
  logic [31:0] m_sc = 0, m_fc = 0, n_sc, n_fc;

  function automatic logic [1:0] exp_fwd(input logic [4:0] rs, input ins_t m, input ins_t w);
    if (m.v && m.rw && m.rd != 0 && m.rd == rs) return 2'b10;
    if (w.v && w.rw && w.rd != 0 && w.rd == rs) return 2'b01;
    return 2'b00;
  endfunction

  always @(negedge clk) begin : model_chk
    int         kind;
    logic [7:0] ev, av;
    ins_t       e, m, w;
    e = pipe[0]; m = pipe[1]; w = pipe[2];

    if (reset) kind = K_RST;
    else if (m.v && m.mop && !hz.mem_ready) kind = K_MST;
    else if (e.v && hz.ex_busy) kind = K_XST;
    else if (e.v && hz.ex_branch_taken) kind = K_BR;
    else if (hz.id_valid && e.v && e.mr && e.rd != 0 &&
             ((hz.id_use_rs1 && hz.id_rs1 == e.rd) || (hz.id_use_rs2 && hz.id_rs2 == e.rd)))
      kind = K_LU;
    else kind = K_NONE;

    // {stall_f, stall_d, flush_d, flush_e, freeze_e, freeze_m, bubble_m, bubble_w}
    case (kind)
      K_RST:   ev = 8'b0011_0011;
      K_MST:   ev = 8'b1100_1101;
      K_XST:   ev = 8'b1100_1010;
      K_BR:    ev = 8'b0011_0000;
      K_LU:    ev = 8'b1101_0000;
      default: ev = 8'b0000_0000;
    endcase
    av = {hz.stall_f, hz.stall_d, hz.flush_d, hz.flush_e,
          hz.freeze_e, hz.freeze_m, hz.bubble_m, hz.bubble_w};
    chk("ctl", 32'(av), 32'(ev));
    chk("fwd_a", 32'(hz.fwd_a), reset ? 32'd0 : 32'(exp_fwd(e.rs1, m, w)));
    chk("fwd_b", 32'(hz.fwd_b), reset ? 32'd0 : 32'(exp_fwd(e.rs2, m, w)));
    if (!reset) begin
      chk("stall_cnt", hz.stall_cnt, m_sc);
      chk("flush_cnt", hz.flush_cnt, m_fc);
    end

    nxt[0] = e; nxt[1] = m; nxt[2] = w;
    case (kind)
      K_RST: begin nxt[0] = '0; nxt[1] = '0; nxt[2] = '0; end
      K_MST: nxt[2] = '0;
      K_XST: begin nxt[2] = m; nxt[1] = '0; end
      K_BR, K_LU: begin nxt[2] = m; nxt[1] = e; nxt[0] = '0; end
      default: begin
        nxt[2] = m; nxt[1] = e;
        nxt[0] = '{v: hz.id_valid, rs1: hz.id_rs1, rs2: hz.id_rs2, rd: hz.id_rd,
                   rw: hz.id_regwrite, mr: hz.id_memread,
                   mop: hz.id_memread | hz.id_memwrite};
      end
    endcase
    n_sc = reset ? 32'd0 : m_sc + 32'(ev[7]);
    n_fc = reset ? 32'd0 : m_fc + 32'(ev[5]);
  end

  always @(posedge clk) begin
    pipe[0] <= nxt[0];
    pipe[1] <= nxt[1];
    pipe[2] <= nxt[2];
    m_sc    <= n_sc;
    m_fc    <= n_fc;
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();  @(posedge clk); #1; endtask
  task automatic look(); @(negedge clk); #1; endtask

  task automatic ins(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                     input logic u2, input logic [4:0] rd, input logic rw,
                     input logic mr, input logic mw);
    hz.id_valid = 1'b1; hz.id_rs1 = rs1; hz.id_rs2 = rs2;
    hz.id_use_rs1 = u1; hz.id_use_rs2 = u2; hz.id_rd = rd;
    hz.id_regwrite = rw; hz.id_memread = mr; hz.id_memwrite = mw;
  endtask

  task automatic nop();
    hz.id_valid = 1'b0; hz.id_rs1 = 5'd0; hz.id_rs2 = 5'd0;
    hz.id_use_rs1 = 1'b0; hz.id_use_rs2 = 1'b0; hz.id_rd = 5'd0;
    hz.id_regwrite = 1'b0; hz.id_memread = 1'b0; hz.id_memwrite = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    hz.ex_branch_taken = 1'b0; hz.ex_busy = 1'b0; hz.mem_ready = 1'b1;
    nop();
    look();
    chk("rst_flush_d", 32'(hz.flush_d), 32'd1);
    chk("rst_flush_e", 32'(hz.flush_e), 32'd1);
    chk("rst_stall_f", 32'(hz.stall_f), 32'd0);
    chk("rst_bubbles", 32'({hz.bubble_m, hz.bubble_w}), 32'd3);
    cyc(); look();
    cyc(); reset = 1'b0; look();
    chk("post_rst_stall_cnt", hz.stall_cnt, 32'd0);

    // back-to-back ALU forwarding from M, from W, and never for x0
    cyc(); ins(5'd1, 5'd2, 1, 1, 5'd3, 1, 0, 0); look();
    cyc(); ins(5'd6, 5'd3, 1, 1, 5'd4, 1, 0, 0); look();
    cyc(); nop(); look();
    chk("fwd_b_from_m", 32'(hz.fwd_b), 32'd2);
    chk("fwd_a_none", 32'(hz.fwd_a), 32'd0);
    cyc(); ins(5'd1, 5'd2, 1, 1, 5'd3, 1, 0, 0); look();
    cyc(); nop(); look();
    cyc(); ins(5'd6, 5'd3, 1, 1, 5'd4, 1, 0, 0); look();
    cyc(); nop(); look();
    chk("fwd_b_from_w", 32'(hz.fwd_b), 32'd1);
    cyc(); ins(5'd1, 5'd2, 1, 1, 5'd0, 1, 0, 0); look();
    cyc(); ins(5'd6, 5'd0, 1, 1, 5'd4, 1, 0, 0); look();
    cyc(); nop(); look();
    chk("fwd_b_x0", 32'(hz.fwd_b), 32'd0);

    // load-use: one bubble, then W forwarding
    cyc(); ins(5'd1, 5'd0, 1, 0, 5'd5, 1, 1, 0); look();
    cyc(); ins(5'd5, 5'd2, 1, 1, 5'd6, 1, 0, 0); look();
    chk("lu_stall", 32'({hz.stall_f, hz.stall_d, hz.flush_e, hz.flush_d}), 32'hE);
    cyc(); look();
    chk("lu_released", 32'(hz.stall_f), 32'd0);
    cyc(); nop(); look();
    chk("lu_fwd_a_w", 32'(hz.fwd_a), 32'd1);
    chk("lu_stall_cnt", hz.stall_cnt, 32'd1);

    // store waiting in M for three cycles
    cyc(); ins(5'd1, 5'd7, 1, 1, 5'd0, 0, 0, 1); look();
    cyc(); nop(); look();
    cyc(); hz.mem_ready = 1'b0; look();
    chk("mst_ctl", 32'({hz.freeze_m, hz.freeze_e, hz.stall_f, hz.bubble_w}), 32'hF);
    cyc(); look();
    cyc(); look();
    cyc(); hz.mem_ready = 1'b1; look();
    chk("mst_done", 32'(hz.stall_f), 32'd0);
    chk("mst_stall_cnt", hz.stall_cnt, 32'd4);

    // taken branch beats simultaneous load-use
    cyc(); ins(5'd1, 5'd0, 1, 0, 5'd8, 1, 1, 0); look();
    cyc(); ins(5'd8, 5'd2, 1, 1, 5'd9, 1, 0, 0); hz.ex_branch_taken = 1'b1; look();
    chk("br_flush", 32'({hz.flush_d, hz.flush_e, hz.stall_f, hz.stall_d}), 32'hC);
    chk("br_flush_cnt_before", hz.flush_cnt, 32'd0);
    cyc(); nop(); hz.ex_branch_taken = 1'b0; look();
    chk("br_flush_cnt_after", hz.flush_cnt, 32'd1);

    // multicycle E for four cycles, then memory wait overriding busy
    cyc(); ins(5'd1, 5'd2, 1, 1, 5'd9, 1, 0, 0); look();
    cyc(); ins(5'd9, 5'd2, 1, 1, 5'd10, 1, 0, 0); look();
    cyc(); nop(); hz.ex_busy = 1'b1; look();
    chk("xst_ctl", 32'({hz.freeze_e, hz.bubble_m, hz.freeze_m, hz.stall_f}), 32'hD);
    chk("xst_fwd_a_m", 32'(hz.fwd_a), 32'd2);
    cyc(); look();
    chk("xst_fwd_a_w", 32'(hz.fwd_a), 32'd1);
    cyc(); look();
    cyc(); look();
    cyc(); hz.ex_busy = 1'b0; look();
    chk("xst_done", 32'(hz.freeze_e), 32'd0);
    cyc(); ins(5'd1, 5'd0, 1, 0, 5'd11, 1, 1, 0); look();
    cyc(); ins(5'd1, 5'd2, 1, 1, 5'd12, 1, 0, 0); look();
    cyc(); nop(); hz.mem_ready = 1'b0; hz.ex_busy = 1'b1; look();
    chk("mst_over_xst", 32'({hz.freeze_m, hz.bubble_m, hz.bubble_w}), 32'h5);
    cyc(); hz.mem_ready = 1'b1; look();
    chk("xst_after_mst", 32'({hz.freeze_m, hz.bubble_m}), 32'h1);
    cyc(); hz.ex_busy = 1'b0; look();
    chk("mix_stall_cnt", hz.stall_cnt, 32'd10);

    // reset in the middle of a memory wait
    cyc(); ins(5'd1, 5'd7, 1, 1, 5'd0, 0, 0, 1); look();
    cyc(); nop(); look();
    cyc(); hz.mem_ready = 1'b0; look();
    chk("pre_rst_mst", 32'(hz.stall_f), 32'd1);
    cyc(); reset = 1'b1; look();
    chk("mid_rst_ctl", 32'({hz.flush_d, hz.flush_e, hz.stall_f, hz.freeze_m}), 32'hC);
    cyc(); reset = 1'b0; look();
    chk("after_rst_stall", 32'({hz.stall_f, hz.freeze_m}), 32'd0);
    chk("after_rst_stall_cnt", hz.stall_cnt, 32'd0);
    chk("after_rst_flush_cnt", hz.flush_cnt, 32'd0);
    cyc(); hz.mem_ready = 1'b1; look();
    cyc(); look();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
